// File: rtl/cordic_vectoring_controller_if.sv
// cordic_vectoring_controller_if: start/done handshake plus datapath control bundle for the CORDIC vectoring sequencer.
interface cordic_vectoring_controller_if #(parameter int ITER_WIDTH = 4);
  logic                  start;
  logic                  y_sign;
  logic                  x_sign;
  logic                  busy;
  logic                  done;
  logic                  init_load;
  logic                  iter_load;
  logic                  prerot_load;
  logic [ITER_WIDTH-1:0] shift_amt;
  logic [ITER_WIDTH-1:0] lut_addr;
  logic [1:0]            alu_op_x;
  logic [1:0]            alu_op_y;
  logic [1:0]            alu_op_z;
  modport master (
    output start, y_sign, x_sign,
    input  busy, done, init_load, iter_load, prerot_load, shift_amt, lut_addr, alu_op_x, alu_op_y, alu_op_z
  );
  modport slave (
    input  start, y_sign, x_sign,
    output busy, done, init_load, iter_load, prerot_load, shift_amt, lut_addr, alu_op_x, alu_op_y, alu_op_z
  );
endinterface

// File: rtl/cordic_vectoring_controller.sv
// cordic_vectoring_controller: IDLE/LOAD/(PREROT)/ITER/DONE sequencer for CORDIC vectoring mode.
// Define CORDIC_QUADRANT_CORR_EN to add the left-half-plane pre-rotation state.
module cordic_vectoring_controller #(
  parameter int ITERATIONS = 16,
  parameter int ITER_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  cordic_vectoring_controller_if.slave bus
);
  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] NOP = 2'd2;
  localparam logic [ITER_WIDTH-1:0] LAST = ITER_WIDTH'(ITERATIONS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, PREROT, ITER, DONE} state_t;
  state_t state_q, state_d;
  logic [ITER_WIDTH-1:0] cnt_q, cnt_d, idx;
  logic busy, done, init_load, iter_load, prerot_load;
  logic [1:0] op_x, op_y, op_z;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = bus.start ? LOAD : IDLE;
      LOAD: begin
        cnt_d = '0;
`ifdef CORDIC_QUADRANT_CORR_EN
        state_d = PREROT;
`else
        state_d = ITER;
`endif
      end
      PREROT: state_d = ITER;
      ITER: begin
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? DONE : ITER;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Op selects follow y_sign combinationally so they track the live y register.
  always_comb begin
    busy        = state_q != IDLE;
    done        = state_q == DONE;
    init_load   = state_q == LOAD;
    iter_load   = state_q == ITER;
    prerot_load = 1'b0;
`ifdef CORDIC_QUADRANT_CORR_EN
    prerot_load = (state_q == PREROT) && bus.x_sign;
`endif
    idx  = iter_load ? cnt_q : '0;
    op_x = iter_load ? (bus.y_sign ? SUB : ADD) : NOP;
    op_y = iter_load ? (bus.y_sign ? ADD : SUB) : NOP;
    op_z = op_x;
  end
`ifndef CORDIC_QUADRANT_CORR_EN
  logic unused_x_sign;
  assign unused_x_sign = bus.x_sign;
`endif
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.init_load   = init_load;
  assign bus.iter_load   = iter_load;
  assign bus.prerot_load = prerot_load;
  assign bus.shift_amt   = idx;
  assign bus.lut_addr    = idx;
  assign bus.alu_op_x    = op_x;
  assign bus.alu_op_y    = op_y;
  assign bus.alu_op_z    = op_z;
endmodule
